score_update_scheduler: RTL

//  Arbitrates BCD score add/subtract requests from NUM_REQ sources (collision logic, bonus, penalty).

---
 rtl/score_pkg.sv | 43 ++++
 rtl/bcd_digit_alu.sv | 56 +++++
 rtl/score_update_scheduler.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/score_pkg.sv
// -----------------------------------------------------------------------------
// score_pkg
// Shared types and constants for the BCD score update scheduler.
//   SCORE_DIGITS  : default number of BCD digits in a score / amount
//   bcd_digit_t   : one BCD digit
//   bcd_score_t   : packed score, nibble k holds the 10^k digit
//   score_req_t   : queued request {sub, amount}
//   sched_state_t : engine state
//   BCD_MAX       : largest representable score (all nines)
//   bcd_clamp()   : forces every digit above 9 down to 9
// -----------------------------------------------------------------------------
package score_pkg;

  localparam int SCORE_DIGITS = 6;

  typedef logic [3:0]                bcd_digit_t;
  typedef logic [4*SCORE_DIGITS-1:0] bcd_score_t;

  typedef struct packed {
    logic       sub;
    bcd_score_t amount;
  } score_req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DIGIT  = 2'd2,
    COMMIT = 2'd3
  } sched_state_t;

  localparam bcd_score_t BCD_MAX = {SCORE_DIGITS{4'h9}};

  // Requesters may present non-decimal nibbles; the engine only ever sees 0..9.
  function automatic bcd_score_t bcd_clamp(input bcd_score_t v);
    bcd_score_t r;
    r = '0;
    for (int k = 0; k < SCORE_DIGITS; k++) begin
      r[4*k +: 4] = (v[4*k +: 4] > 4'd9) ? 4'd9 : v[4*k +: 4];
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_digit_alu.sv
// -----------------------------------------------------------------------------
// bcd_digit_alu
// Combinational single-digit BCD adder/subtractor with carry/borrow chaining.
//   sub_i   : 1 = a - b - cin, 0 = a + b + cin
//   a_i     : running score digit (0..9)
//   b_i     : request amount digit (0..9)
//   cin_i   : carry (add) or borrow (sub) from the lower digit
//   y_o     : result digit (0..9)
//   cout_o  : carry (add) or borrow (sub) into the next digit
// -----------------------------------------------------------------------------
module bcd_digit_alu
  import score_pkg::*;
(
  input  logic       sub_i,
  input  bcd_digit_t a_i,
  input  bcd_digit_t b_i,
  input  logic       cin_i,
  output bcd_digit_t y_o,
  output logic       cout_o
);

  logic [4:0] sum;
  logic [4:0] sum_adj;
  logic [4:0] diff;
  logic [4:0] diff_adj;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/case can leave it unassigned and infer a latch.
    y_o    = '0;
    cout_o = 1'b0;

    sum      = {1'b0, a_i} + {1'b0, b_i} + {4'b0, cin_i};
    sum_adj  = sum - 5'd10;
    // Range is -10..9, so bit 4 is the sign of the 5-bit two's complement.
    diff     = {1'b0, a_i} - {1'b0, b_i} - {4'b0, cin_i};
    diff_adj = diff + 5'd10;

    if (sub_i) begin
      if (diff[4]) begin
        y_o    = diff_adj[3:0];
        cout_o = 1'b1;
      end else begin
        y_o    = diff[3:0];
      end
    end else begin
      if (sum > 5'd9) begin
        y_o    = sum_adj[3:0];
        cout_o = 1'b1;
      end else begin
        y_o    = sum[3:0];
      end
    end
  end

endmodule

// File: rtl/score_update_scheduler.sv
// -----------------------------------------------------------------------------
// score_update_scheduler
// Round-robin arbitration of BCD score add/subtract requests into a small
// FIFO, applied one at a time by a digit-serial BCD engine (LSD first).
//
// Ports
//   clk           : system clock
//   resetN        : asynchronous active-low reset
//   startOfFrame  : 1-cycle frame pulse; samples score into score_frame
//   clear_score   : synchronous clear (flush queue, abort engine, score := 0)
//   req_valid     : per-requester valid
//   req_sub       : per-requester 1 = subtract, 0 = add
//   req_amount    : per-requester BCD amount, requester i at [i*4*DIGITS +: 4*DIGITS]
//   req_ready     : per-requester accept strobe (transfer on valid & ready)
//   score         : live score register
//   score_frame   : score captured at startOfFrame
//   busy          : engine active or queue non-empty
//   fifo_full     : request queue full
//   range_event   : 1-cycle pulse when a result leaves 0..10^DIGITS-1
//
// Build option
//   SCORE_SATURATE_EN : when defined, overflow commits all nines and underflow
//                       commits zero; otherwise results wrap modulo 10^DIGITS.
//
// DIGITS sizes the ports and digit counter; the shared score types are sized
// by score_pkg::SCORE_DIGITS, so the two must be kept equal.
// -----------------------------------------------------------------------------
module score_update_scheduler
  import score_pkg::*;
#(
  parameter int NUM_REQ    = 3,
  parameter int FIFO_DEPTH = 4,
  parameter int DIGITS     = SCORE_DIGITS
) (
  input  logic                        clk,
  input  logic                        resetN,
  input  logic                        startOfFrame,
  input  logic                        clear_score,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_sub,
  input  logic [NUM_REQ*4*DIGITS-1:0] req_amount,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [4*DIGITS-1:0]         score,
  output logic [4*DIGITS-1:0]         score_frame,
  output logic                        busy,
  output logic                        fifo_full,
  output logic                        range_event
);

  localparam int PTR_W  = (NUM_REQ > 1)    ? $clog2(NUM_REQ)    : 1;
  localparam int AW     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int DCNT_W = (DIGITS > 1)     ? $clog2(DIGITS)     : 1;

  // ---------------------------------------------------------------------------
  // Round-robin arbiter
  // ---------------------------------------------------------------------------
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               grant_any;
  logic               push;
  score_req_t         push_entry;

  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = rr_ptr_q;
    grant_any = 1'b0;
    idx       = 0;
    // Search begins just after the last winner, wrapping round to it last.
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(rr_ptr_q) + k) % NUM_REQ;
      if (!grant_any && req_valid[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = PTR_W'(idx);
      end
    end
  end

  // Full is the registered occupancy, so a pop this cycle never frees a slot
  // for a same-cycle push.
  assign push      = grant_any && !fifo_full && !clear_score;
  assign req_ready = push ? grant : '0;

  always_comb begin
    push_entry.sub    = req_sub[grant_idx];
    push_entry.amount = bcd_clamp(req_amount[grant_idx*4*DIGITS +: 4*DIGITS]);
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (clear_score) begin
      rr_ptr_d = PTR_W'(NUM_REQ - 1);
    end else if (push) begin
      rr_ptr_d = grant_idx;
    end
  end

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  score_req_t       fifo_mem [FIFO_DEPTH];
  score_req_t       head;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             pop;

  sched_state_t state_q, state_d;

  assign fifo_full = (count_q == CNT_W'(FIFO_DEPTH));
  assign head      = fifo_mem[rd_ptr_q];
  assign pop       = (state_q == IDLE) && (count_q != '0) && !clear_score;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_score) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // NOTE: queue storage is deliberately left without reset; occupancy is
  // carried entirely by the pointers and count, so stale entries are unread.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= push_entry;
  end

  // ---------------------------------------------------------------------------
  // Digit-serial BCD engine
  // ---------------------------------------------------------------------------
  logic                op_sub_q, op_sub_d;
  bcd_score_t          amt_q, amt_d;
  bcd_score_t          acc_q, acc_d;
  logic                carry_q, carry_d;
  logic [DCNT_W-1:0]   dig_cnt_q, dig_cnt_d;
  bcd_score_t          score_q, score_d;
  bcd_score_t          score_frame_q, score_frame_d;
  logic                range_q, range_d;
  bcd_score_t          commit_value;
  bcd_digit_t          alu_y;
  logic                alu_cout;

  // Operands are shifted right one digit per cycle, so the ALU always works
  // on bit 3:0 and the result digit enters at the top of the accumulator.
  bcd_digit_alu u_alu (
    .sub_i  (op_sub_q),
    .a_i    (acc_q[3:0]),
    .b_i    (amt_q[3:0]),
    .cin_i  (carry_q),
    .y_o    (alu_y),
    .cout_o (alu_cout)
  );

  always_comb begin
`ifdef SCORE_SATURATE_EN
    if (carry_q) begin
      commit_value = op_sub_q ? '0 : BCD_MAX;
    end else begin
      commit_value = acc_q;
    end
`else
    commit_value = acc_q;
`endif
  end

  always_comb begin
    state_d   = state_q;
    op_sub_d  = op_sub_q;
    amt_d     = amt_q;
    acc_d     = acc_q;
    carry_d   = carry_q;
    dig_cnt_d = dig_cnt_q;
    score_d   = score_q;
    range_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pop) begin
          op_sub_d = head.sub;
          amt_d    = head.amount;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        acc_d     = score_q;
        carry_d   = 1'b0;
        dig_cnt_d = '0;
        state_d   = DIGIT;
      end
      DIGIT: begin
        acc_d   = {alu_y, acc_q[4*DIGITS-1:4]};
        amt_d   = amt_q >> 4;
        carry_d = alu_cout;
        if (dig_cnt_q == DCNT_W'(DIGITS - 1)) begin
          state_d = COMMIT;
        end else begin
          dig_cnt_d = dig_cnt_q + DCNT_W'(1);
        end
      end
      COMMIT: begin
        // Carry/borrow out of the top digit is the out-of-range indication.
        range_d = carry_q;
        score_d = commit_value;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (clear_score) begin
      state_d = IDLE;
      score_d = '0;
      range_d = 1'b0;
    end
  end

  // Frame copy takes the register's current value, i.e. the pre-commit score
  // when a commit lands on the same edge.
  always_comb begin
    score_frame_d = score_frame_q;
    if (startOfFrame) score_frame_d = score_q;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      rr_ptr_q      <= PTR_W'(NUM_REQ - 1);
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      state_q       <= IDLE;
      op_sub_q      <= 1'b0;
      amt_q         <= '0;
      acc_q         <= '0;
      carry_q       <= 1'b0;
      dig_cnt_q     <= '0;
      score_q       <= '0;
      score_frame_q <= '0;
      range_q       <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      state_q       <= state_d;
      op_sub_q      <= op_sub_d;
      amt_q         <= amt_d;
      acc_q         <= acc_d;
      carry_q       <= carry_d;
      dig_cnt_q     <= dig_cnt_d;
      score_q       <= score_d;
      score_frame_q <= score_frame_d;
      range_q       <= range_d;
    end
  end

  assign score       = score_q;
  assign score_frame = score_frame_q;
  assign range_event = range_q;
  assign busy        = (state_q != IDLE) || (count_q != '0);

endmodule
